// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO in front of a UART transmitter.
// Byte stores from the MMU are queued in the FIFO. The transmitter drains
// the FIFO onto uartTxPin, LSB first, with the line idling high.
// The default frame is 8N1.
// Defining UART_TX_PARITY_EN adds an even-parity bit, giving 8E1 frames.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// S_IDLE   | line high; pops the FIFO head into shift when level != 0
// S_START  | start bit (0) for CLKS_PER_BIT cycles
// S_DATA   | shift[bit_idx] for CLKS_PER_BIT cycles per bit, bit 0 first
// S_PARITY | even parity of shift (only with UART_TX_PARITY_EN)
// S_STOP   | stop bit (1) for CLKS_PER_BIT cycles, then back to S_IDLE
//
// uartTxPin is registered from the current state. The line therefore lags
// the FSM by one cycle, and the start bit appears two edges after the write.

module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic                          wrEn,
    input  logic [7:0]                    wrData,
    output logic                          full,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    output logic                          txBusy,
    output logic                          ovf,
    input  logic                          ovfClr,
    output logic                          uartTxPin
);

    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int LW    = AW + 1;
    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    localparam logic [LW-1:0]    DEPTH_L = LW'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
`ifdef UART_TX_PARITY_EN
        , S_PARITY
`endif
    } tx_state_t;

    // FIFO storage and pointers
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [LW-1:0] level_nxt;
    logic          push;
    logic          pop;

    // Transmitter
    tx_state_t     state;
    tx_state_t     state_nxt;
    logic [CNT_W-1:0] bit_cnt;
    logic [CNT_W-1:0] bit_cnt_nxt;
    logic [2:0]    bit_idx;
    logic [2:0]    bit_idx_nxt;
    logic [7:0]    shift;
    logic          tx_nxt;
    logic          cnt_tc;

    // A write is only taken when the FIFO is not full at the edge; a
    // simultaneous pop does not make room for it.
    assign push   = wrEn && !full;
    assign cnt_tc = (bit_cnt == '0);
    assign txBusy = (state != S_IDLE) || (level != '0);

    // Occupancy after this edge; push and pop together cancel out
    always_comb begin
        level_nxt = level;
        case ({push, pop})
            2'b10:   level_nxt = level + 1'b1;
            2'b01:   level_nxt = level - 1'b1;
            default: level_nxt = level;
        endcase
    end

    // FIFO storage write; contents need no reset since level gates reads
    always_ff @(posedge CLK) begin
        if (push) begin
            mem[wr_ptr] <= wrData;
        end
    end

    // FIFO pointers, registered level and full
    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            full   <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            level <= level_nxt;
            full  <= (level_nxt == DEPTH_L);
        end
    end

    // Sticky overflow flag; a dropped write beats a clear on the same edge
    always_ff @(posedge CLK) begin
        if (RST) begin
            ovf <= 1'b0;
        end else if (wrEn && full) begin
            ovf <= 1'b1;
        end else if (ovfClr) begin
            ovf <= 1'b0;
        end
    end

    // FSM state register and bit timing
    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= S_IDLE;
            bit_cnt <= '0;
            bit_idx <= '0;
        end else begin
            state   <= state_nxt;
            bit_cnt <= bit_cnt_nxt;
            bit_idx <= bit_idx_nxt;
        end
    end

    // Shift register loads the FIFO head on a pop and holds it for the frame
    always_ff @(posedge CLK) begin
        if (RST) begin
            shift <= '0;
        end else if (pop) begin
            shift <= mem[rd_ptr];
        end
    end

    // Line output flop; reset forces the line high, aborting any frame
    always_ff @(posedge CLK) begin
        if (RST) begin
            uartTxPin <= 1'b1;
        end else begin
            uartTxPin <= tx_nxt;
        end
    end

    // Next-state, bit timer, pop request and line value for the current state
    always_comb begin
        state_nxt   = state;
        bit_cnt_nxt = bit_cnt;
        bit_idx_nxt = bit_idx;
        pop         = 1'b0;
        tx_nxt      = 1'b1;
        case (state)
            S_IDLE: begin
                tx_nxt = 1'b1;
                if (level != '0) begin
                    pop         = 1'b1;
                    state_nxt   = S_START;
                    bit_cnt_nxt = CNT_MAX;
                end
            end
            S_START: begin
                tx_nxt = 1'b0;
                if (cnt_tc) begin
                    state_nxt   = S_DATA;
                    bit_cnt_nxt = CNT_MAX;
                    bit_idx_nxt = '0;
                end else begin
                    bit_cnt_nxt = bit_cnt - 1'b1;
                end
            end
            S_DATA: begin
                tx_nxt = shift[bit_idx];
                if (cnt_tc) begin
                    bit_cnt_nxt = CNT_MAX;
                    if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_nxt = S_PARITY;
`else
                        state_nxt = S_STOP;
`endif
                    end else begin
                        bit_idx_nxt = bit_idx + 1'b1;
                    end
                end else begin
                    bit_cnt_nxt = bit_cnt - 1'b1;
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                tx_nxt = ^shift;
                if (cnt_tc) begin
                    state_nxt   = S_STOP;
                    bit_cnt_nxt = CNT_MAX;
                end else begin
                    bit_cnt_nxt = bit_cnt - 1'b1;
                end
            end
`endif
            S_STOP: begin
                tx_nxt = 1'b1;
                if (cnt_tc) begin
                    state_nxt = S_IDLE;
                end else begin
                    bit_cnt_nxt = bit_cnt - 1'b1;
                end
            end
            default: begin
                state_nxt = S_IDLE;
                tx_nxt    = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Testbench for uart_tx_fifo with CLKS_PER_BIT=4 and FIFO_DEPTH=4.
// A line monitor decodes every frame on uartTxPin.
// Each decoded frame is checked against a queue of the bytes the bench
// expects the FIFO to accept.

module tb_uart_tx_fifo;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int PERIOD = NBITS * CPB + 1;

    logic       CLK;
    logic       RST;
    logic       wrEn;
    logic [7:0] wrData;
    logic       full;
    logic [2:0] level;
    logic       txBusy;
    logic       ovf;
    logic       ovfClr;
    logic       uartTxPin;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int rst_gen = 0;
    bit gap_on = 0;
    int last_start = -1;
    logic [7:0] sb_q[$];

    uart_tx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .CLK(CLK), .RST(RST), .wrEn(wrEn), .wrData(wrData), .full(full),
        .level(level), .txBusy(txBusy), .ovf(ovf), .ovfClr(ovfClr),
        .uartTxPin(uartTxPin)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Drive one write for one edge; acc says whether the FIFO should take it
    task automatic put(input logic [7:0] b, input bit acc);
        wrEn   = 1'b1;
        wrData = b;
        if (acc) sb_q.push_back(b);
        @(negedge CLK);
        wrEn = 1'b0;
    endtask

    // Wait (bounded) until every expected byte has come out and the DUT is idle
    task automatic drain(input string tag, input int limit);
        for (int i = 0; i < limit && (sb_q.size() != 0 || txBusy); i++) @(negedge CLK);
        repeat (CPB) @(negedge CLK);
        chk({tag, "_sb_empty"}, 32'(sb_q.size()), 32'd0);
        chk({tag, "_idle"}, 32'(txBusy), 32'd0);
    endtask

    // Ideal line value k edges after the write edge of byte b into an idle FIFO
    function automatic logic exp_line(input logic [7:0] b, input int k);
        int j;
        if (k < 2) return 1'b1;
        j = (k - 2) / CPB;
        if (j == 0) return 1'b0;
        if (j <= 8) return b[j-1];
`ifdef UART_TX_PARITY_EN
        if (j == 9) return ^b;
`endif
        return 1'b1;
    endfunction

    // Line monitor: decodes frames and checks them against the scoreboard
    logic [7:0] rx_b;
    logic       rx_start;
    logic       rx_par;
    logic       rx_stop;
    int         rx_gen;
    int         rx_t0;
    logic [8:0] rx_exp;
    initial begin
        forever begin
            @(negedge CLK);
            if (RST === 1'b0 && uartTxPin === 1'b0) begin
                rx_gen = rst_gen;
                rx_t0  = cyc;
                @(negedge CLK);
                rx_start = uartTxPin;
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge CLK);
                    rx_b[i] = uartTxPin;
                end
                rx_par = 1'b0;
`ifdef UART_TX_PARITY_EN
                repeat (CPB) @(negedge CLK);
                rx_par = uartTxPin;
`endif
                repeat (CPB) @(negedge CLK);
                rx_stop = uartTxPin;
                if (rx_gen == rst_gen) begin
                    rx_exp = (sb_q.size() != 0) ? {1'b0, sb_q.pop_front()} : 9'h100;
                    chk("rx_byte", 32'({1'b0, rx_b}), 32'(rx_exp));
                    chk("rx_start", 32'(rx_start), 32'd0);
                    chk("rx_stop", 32'(rx_stop), 32'd1);
`ifdef UART_TX_PARITY_EN
                    chk("rx_parity", 32'(rx_par), 32'(^rx_b));
`endif
                    if (gap_on) begin
                        if (last_start >= 0) chk("frame_gap", 32'(rx_t0 - last_start), 32'(PERIOD));
                        last_start = rx_t0;
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    logic pin_s  [0:63];
    logic busy_s [0:63];
    logic [2:0] lvl_e [0:5];
    logic       full_e[0:5];
    int lows;

    initial begin
        RST = 1'b1; wrEn = 1'b0; wrData = 8'h00; ovfClr = 1'b0;
        repeat (3) @(negedge CLK);
        chk("rst_pin", 32'(uartTxPin), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_busy", 32'(txBusy), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        RST = 1'b0;
        repeat (3) @(negedge CLK);

        // Single byte 0xA5: exact line timing and txBusy
        put(8'hA5, 1'b1);
        for (int k = 0; k <= NBITS*CPB + 2; k++) begin
            if (k != 0) @(negedge CLK);
            pin_s[k]  = uartTxPin;
            busy_s[k] = txBusy;
        end
        for (int k = 1; k <= NBITS*CPB + 2; k++)
            chk($sformatf("a5_pin_k%0d", k), 32'(pin_s[k]), 32'(exp_line(8'hA5, k)));
        chk("a5_busy_start", 32'(busy_s[0]), 32'd1);
        chk("a5_busy_stop", 32'(busy_s[NBITS*CPB]), 32'd1);
        chk("a5_busy_end", 32'(busy_s[NBITS*CPB + 2]), 32'd0);
        drain("a5", 40);

        // Fill a depth-4 FIFO with 0x01..0x06; 0x06 is dropped
        lvl_e  = '{3'd1, 3'd1, 3'd2, 3'd3, 3'd4, 3'd4};
        full_e = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 6; i++) begin
            put(8'(i + 1), i < 5);
            chk($sformatf("fill_level_%0d", i), 32'(level), 32'(lvl_e[i]));
            chk($sformatf("fill_full_%0d", i), 32'(full), 32'(full_e[i]));
            chk($sformatf("fill_ovf_%0d", i), 32'(ovf), 32'(i == 5));
        end
        // Clear and a dropped write on the same edge: ovf stays set
        wrEn = 1'b1; wrData = 8'h77; ovfClr = 1'b1;
        @(negedge CLK);
        wrEn = 1'b0; ovfClr = 1'b0;
        chk("ovf_set_wins", 32'(ovf), 32'd1);
        chk("ovf_full_level", 32'(level), 32'd4);
        ovfClr = 1'b1;
        @(negedge CLK);
        ovfClr = 1'b0;
        chk("ovf_cleared", 32'(ovf), 32'd0);
        drain("fill", 8*PERIOD);

        // Continuous writes: back-to-back frame spacing
        last_start = -1;
        gap_on = 1'b1;
        put(8'h3C, 1'b1);
        put(8'hC3, 1'b1);
        put(8'h5A, 1'b1);
        for (int j = 0; j < 4; j++) begin
            repeat (PERIOD - 1) @(negedge CLK);
            put(8'(8'h80 + j * 8'h11), 1'b1);
        end
        drain("gap", 8*PERIOD);
        gap_on = 1'b0;

        // Reset in the middle of the second of three queued bytes
        put(8'h11, 1'b1);
        put(8'h22, 1'b1);
        put(8'h33, 1'b1);
        repeat (PERIOD + 16) @(negedge CLK);
        RST = 1'b1;
        rst_gen++;
        sb_q.delete();
        @(negedge CLK);
        chk("abort_pin", 32'(uartTxPin), 32'd1);
        chk("abort_level", 32'(level), 32'd0);
        chk("abort_busy", 32'(txBusy), 32'd0);
        RST = 1'b0;
        lows = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge CLK);
            if (uartTxPin !== 1'b1) lows++;
        end
        chk("abort_no_restart", 32'(lows), 32'd0);

        // Write and pop on the same edge at level 2
        put(8'h07, 1'b1);
        put(8'h03, 1'b1);
        put(8'hE1, 1'b1);
        chk("same_pre_level", 32'(level), 32'd2);
        repeat (PERIOD - 2) @(negedge CLK);
        chk("same_before_pop", 32'(level), 32'd2);
        put(8'h1E, 1'b1);
        chk("same_level", 32'(level), 32'd2);
        chk("same_full", 32'(full), 32'd0);
        drain("same", 6*PERIOD);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- Memory-mapped UART transmitter behind the MMU's store path. It consumes the byte stores the CPU directs at the UART data address and serialises them onto uartTxPin.
- A FIFO decouples CPU stores from line rate, so the MA phase stalls only when the FIFO is full. The MMU raises memWait on a full FIFO.
- Frame format: 8N1, LSB first, line idles high.

Parameters:
- CLKS_PER_BIT, 434, CLK cycles per serial bit (50 MHz / 115200); legal range 2..65535.
- FIFO_DEPTH, 16, FIFO entries; power of two, at least 2.

Ports:
- CLK  in  1  system clock; all logic on rising edge.
- RST  in  1  synchronous, active-high reset.
- wrEn  in  1  byte-write request from MMU, one cycle per byte.
- wrData  in  8  byte to enqueue.
- full  out  1  FIFO holds FIFO_DEPTH entries; MMU stalls the store.
- level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- txBusy  out  1  FSM not in IDLE, or FIFO non-empty.
- ovf  out  1  sticky flag: a write was dropped because the FIFO was full.
- ovfClr  in  1  clears ovf.
- uartTxPin  out  1  serial output.

Behaviour:
- Single clock (CLK); synchronous active-high reset (RST).
- Reset values: uartTxPin=1, full=0, level=0, txBusy=0, ovf=0. FIFO pointers are zeroed and the FSM enters IDLE.
- Reset mid-frame aborts the frame: uartTxPin=1 on the first edge with RST high, and all queued bytes are discarded.
- FIFO write:
  - A byte is accepted on an edge where wrEn=1 and full=0.
  - If wrEn=1 and full=1, the byte is dropped and ovf is set.
  - full and level are registered and reflect occupancy after the edge.
  - A write and a pop on the same edge leave level unchanged.
  - A write is rejected when full=1, even if a pop occurs on the same edge.
  - Pointers wrap modulo FIFO_DEPTH.
- ovf: ovfClr and a dropped write on the same edge leave ovf=1; set wins.
- FSM states: IDLE, START, DATA, STOP. A bit counter counts CLKS_PER_BIT-1 down to 0. A 3-bit index tracks the data bit.
  - IDLE: uartTxPin=1. If level != 0, pop the head into the shift register and go to START.
    - A byte written while IDLE and empty is popped on the following edge. uartTxPin falls 2 edges after the wrEn edge.
  - START: uartTxPin=0 for CLKS_PER_BIT cycles, then DATA with index 0.
  - DATA: uartTxPin=shift[index] for CLKS_PER_BIT cycles per bit, bit 0 first. After bit 7, go to STOP.
  - STOP: uartTxPin=1 for CLKS_PER_BIT cycles, then IDLE.
- Frame period:
  - Back-to-back frames pass through IDLE for exactly one cycle, so frame period = 10*CLKS_PER_BIT+1 cycles.
  - With UART_TX_PARITY_EN, frame period = 11*CLKS_PER_BIT+1 cycles.
- uartTxPin is driven from a flop (glitch-free).
- txBusy=0 only when the FSM is in IDLE and level=0.
- level never exceeds FIFO_DEPTH and never underflows. A pop occurs only when level != 0.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined: a PARITY state is inserted between DATA and STOP. It drives the even-parity bit (XOR of the 8 data bits) for CLKS_PER_BIT cycles; the frame is 8E1.
- Undefined: no PARITY state and no parity logic; the frame is 8N1.

Test Plan:
- CLKS_PER_BIT=4, reset, write 0xA5 once. Required: line low from edge 2 for 4 cycles, then bits 1,0,1,0,0,1,0,1 at 4 cycles each, then high for 4. txBusy drops 1 cycle after the stop bit.
- FIFO_DEPTH=4, write 0x01..0x06 on consecutive cycles with the line idle:
  - Required: full=1 after 5 writes; 0x01 popped, 0x02..0x05 queued; 0x06 dropped; ovf=1.
  - Transmitted sequence is 0x01..0x05.
  - Assert ovfClr: ovf=0 next cycle.
- Continuous writes keeping the FIFO non-empty, CLKS_PER_BIT=4. Required: successive start-bit falling edges exactly 41 cycles apart; 45 cycles with UART_TX_PARITY_EN.
- RST asserted mid-DATA of the second of 3 queued bytes. Required: uartTxPin=1 and level=0 next edge, txBusy=0. No further start bit until a new write.
- Write and pop on the same edge at level=2. Required: level stays 2; full unchanged.
- UART_TX_PARITY_EN defined, write 0x07. Required: parity bit 1 after bit 7, then stop bit. Write 0x03: parity bit 0.
